// File: rtl/ctrl_unit_pipe.sv
// ID-stage control unit: decodes mode/op_code/S, checks the condition field against NZCV,
// and registers the control word into the ID/EXE register with stall, flush and memory-hold support.
module ctrl_unit_pipe #(
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [3:0]       op_code,
   input  logic             s_in,
   input  logic [3:0]       cond,
   input  logic [3:0]       status,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_ready,
   output logic [CMD_W-1:0] exe_cmd_q,
   output logic             wb_en_q,
   output logic             mem_r_en_q,
   output logic             mem_w_en_q,
   output logic             b_q,
   output logic             s_q,
   output logic             valid_q,
   output logic             illegal_q,
   output logic             busy,
   output logic             mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             pending_flush;

   logic [3:0]       dec_cmd;
   logic [CMD_W-1:0] dec_cmd_ext;
   logic             dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_ill;
   logic             cond_ok;
   logic             flag_n, flag_z, flag_c, flag_v;
   logic             mem_op_q;

   assign {flag_n, flag_z, flag_c, flag_v} = status;

   always_comb begin
      dec_cmd = 4'b0000;
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_b   = 1'b0;
      dec_s   = 1'b0;
      dec_ill = 1'b0;
      case (mode)
         2'b00: begin
            dec_s = s_in;
            case (op_code)
               4'b1101: begin dec_cmd = 4'b0001; dec_wb = 1'b1; end
               4'b1111: begin dec_cmd = 4'b1001; dec_wb = 1'b1; end
               4'b0100: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end
               4'b0101: begin dec_cmd = 4'b0011; dec_wb = 1'b1; end
               4'b0010: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end
               4'b0110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end
               4'b0000: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end
               4'b1100: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end
               4'b0001: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end
               4'b1010: dec_cmd = 4'b0100;
               4'b1000: dec_cmd = 4'b0110;
               default: dec_cmd = 4'b0000;
            endcase
         end
         2'b01: begin
            dec_cmd = 4'b0010;
            dec_mr  = s_in;
            dec_mw  = ~s_in;
            dec_wb  = s_in;
         end
         2'b10:   dec_b   = 1'b1;
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = ~flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = ~flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = ~flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = ~flag_v;
         4'b1000: cond_ok = flag_c & ~flag_z;
         4'b1001: cond_ok = ~flag_c | flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ok = flag_z | (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      dec_cmd_ext      = '0;
      dec_cmd_ext[3:0] = dec_cmd;
   end

   assign mem_op_q = valid_q & (mem_r_en_q | mem_w_en_q);
   assign busy     = mem_op_q & ~mem_ready;

   // A flush that arrives while a memory op is held is remembered and applied once the hold lifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_cmd_q     <= '0;
         wb_en_q       <= 1'b0;
         mem_r_en_q    <= 1'b0;
         mem_w_en_q    <= 1'b0;
         b_q           <= 1'b0;
         s_q           <= 1'b0;
         valid_q       <= 1'b0;
         illegal_q     <= 1'b0;
         pending_flush <= 1'b0;
      end else if (busy) begin
         if (flush) pending_flush <= 1'b1;
      end else if (flush || pending_flush) begin
         exe_cmd_q     <= '0;
         wb_en_q       <= 1'b0;
         mem_r_en_q    <= 1'b0;
         mem_w_en_q    <= 1'b0;
         b_q           <= 1'b0;
         s_q           <= 1'b0;
         valid_q       <= 1'b0;
         illegal_q     <= 1'b0;
         pending_flush <= 1'b0;
      end else if (!stall) begin
         exe_cmd_q  <= dec_cmd_ext;
         wb_en_q    <= dec_wb & cond_ok;
         mem_r_en_q <= dec_mr & cond_ok;
         mem_w_en_q <= dec_mw & cond_ok;
         b_q        <= dec_b  & cond_ok;
         s_q        <= dec_s  & cond_ok;
         valid_q    <= 1'b1;
         illegal_q  <= dec_ill;
      end
   end

   // mem_err is sticky until reset; the FSM keeps waiting after a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (busy) state <= ST_WAIT;
            end
            default: begin
               if (mem_ready) begin
                  state    <= ST_IDLE;
                  wait_cnt <= '0;
               end else begin
                  if (wait_cnt < CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == CNT_LAST) mem_err <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Parametrised successor to the ID-stage control unit. Decodes mode/op_code/S, evaluates the ARM condition field against the NZCV status, and registers the resulting control word into the ID/EXE control register. Supports stall and flush. Holds a memory op in the register while the data memory is not ready, with a timeout error flag. Sits between the instruction decoder and the EXE stage.

Parameters:
CMD_W, 4, width of the exe_cmd field. Must be >= 4; the upper bits are zero-extended.
TIMEOUT, 16, max cycles in MEM_WAIT before mem_err is set. Must be >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mode  in  2  00 data-proc, 01 memory, 10 branch, 11 illegal
op_code  in  4  data-proc opcode
s_in  in  1  S bit; for memory ops, 1=LDR and 0=STR
cond  in  4  condition field
status  in  4  {N,Z,C,V}
stall  in  1  hazard-unit stall
flush  in  1  branch-taken flush
mem_ready  in  1  data memory ready
exe_cmd_q  out  CMD_W  registered ALU command
wb_en_q  out  1  registered write-back enable
mem_r_en_q  out  1  registered memory read enable
mem_w_en_q  out  1  registered memory write enable
b_q  out  1  registered branch
s_q  out  1  registered status-update enable
valid_q  out  1  register holds a live instruction
illegal_q  out  1  registered illegal-mode flag
busy  out  1  memory hold; combinational; upstream must stall
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous: all *_q outputs 0, mem_err 0, FSM in IDLE, wait counter 0, pending-flush bit 0.
- Decode is combinational and is registered after one cycle of latency.
- mode 00 decode, exe_cmd / wb_en:
  - MOV 1101 → 0001 / 1; MVN 1111 → 1001 / 1; ADD 0100 → 0010 / 1; ADC 0101 → 0011 / 1.
  - SUB 0010 → 0100 / 1; SBC 0110 → 0101 / 1; AND 0000 → 0110 / 1; ORR 1100 → 0111 / 1; EOR 0001 → 1000 / 1.
  - CMP 1010 → 0100 / 0; TST 1000 → 0110 / 0.
  - Any other opcode → 0000 / 0.
  - s = s_in.
- mode 01 decode: exe_cmd 0010, mem_r_en = s_in, mem_w_en = !s_in, wb_en = s_in, s = 0.
- mode 10 decode: b = 1; all other fields 0.
- mode 11 decode: illegal = 1; all other fields 0; valid = 1.
- Condition check, using {N,Z,C,V} = status:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 always; 1111 never.
  - On failure: wb/mem_r/mem_w/b/s are forced to 0; exe_cmd and valid are still loaded (the instruction becomes a bubble).
- Register update priority, per clk edge:
  1. busy=1: hold all *_q. If flush=1, set pending_flush.
  2. flush=1 or pending_flush=1: clear all *_q and clear pending_flush.
  3. stall=1: hold.
  4. Otherwise: load the decoded word with valid=1.
- busy = mem_op_q & !mem_ready, where mem_op_q = valid_q & (mem_r_en_q | mem_w_en_q).
- FSM:
  - IDLE → WAIT when mem_op_q & !mem_ready.
  - WAIT → IDLE when mem_ready=1.
  - On the mem_ready=1 cycle busy=0, so the register advances on that edge.
- Wait counter:
  - Cleared in IDLE; increments each WAIT cycle and saturates at TIMEOUT.
  - When the counter reaches TIMEOUT with mem_ready still 0, mem_err is set to 1. It is cleared only by rst. The FSM stays in WAIT.
- A memory op with mem_ready=1 on its first cycle never enters WAIT and causes zero stall cycles.
- Reset mid-WAIT: immediate return to IDLE; the held instruction is discarded.

Test Plan:
- ADD (mode 00, op 0100, s_in 1, cond 1110) → next cycle: exe_cmd_q 0010, wb_en_q 1, s_q 1, valid_q 1.
- CMP, cond EQ, status 0100 → exe_cmd_q 0100, wb_en_q 0, s_q 1. Same with status 0000 → bubble: all enables 0, valid_q 1.
- LDR (mode 01, s_in 1), mem_ready low for 3 cycles → busy high 3 cycles, register held; releases on the mem_ready edge; mem_err 0.
- STR, mem_ready stuck low, TIMEOUT=4 → mem_err rises after 4 WAIT cycles and stays 1 after mem_ready returns.
- flush asserted during busy → held op unchanged; register cleared on the first edge after busy drops. stall+flush together with busy=0 → flush wins.
- Mode 11 → illegal_q 1. Async rst pulse mid-WAIT → all outputs 0 immediately, without waiting for a clk edge.
